dm_sba_engine: RTL and testbench

- Debug-module System Bus Access (SBA) engine.
- Implements the sbcs, sbaddress0 and sbdata0 registers behind the DMI register port.
- Drives a single-outstanding valid/ready memory bus master.
- Successor to the fixed 32-bit-only SBA: adds parametrised address width, 8/16/32-bit accesses, readonaddr/readondata/autoincrement, busy-error and bus-timeout detection.

---
 rtl/dm_sba_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_dm_sba_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_engine.sv
// Debug-module System Bus Access engine: sbcs / sbaddress0 / sbdata0 behind the DMI port, single-outstanding bus master.
// Latency: trigger in cycle N -> bus_req_valid from N+1; sbdata0/sbaddress0 updated the cycle after the response (or timeout).
// Backpressure: request held stable until bus_req_ready; DMI accesses to sbaddress0/sbdata0 while busy set sbbusyerror instead.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dmi_addr/wr/rd/wdata, dmi_rdata DM register port (0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0); rdata is combinational
//   bus_req_*                       request channel (valid/ready), byte address, lane-replicated wdata, byte strobes
//   bus_rsp_*                       response channel (valid only; at least one cycle after the request handshake)
module dm_sba_engine #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [2:0]  SIZE_MASK = 3'b111,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        dmi_addr,
  input  logic              dmi_wr,
  input  logic              dmi_rd,
  input  logic [31:0]       dmi_wdata,
  output logic [31:0]       dmi_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_strb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata,
  input  logic              bus_rsp_err
);

  localparam logic [6:0] A_SBCS   = 7'h38;
  localparam logic [6:0] A_SBADDR = 7'h39;
  localparam logic [6:0] A_SBDATA = 7'h3C;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  // Widened so an sbaccess code of 3 indexes a defined (unsupported) bit.
  localparam logic [3:0]       MASK4    = {1'b0, SIZE_MASK};

  logic [1:0]        state_q, state_d;
  logic              busyerr_q, busyerr_d;
  logic              rdonaddr_q, rdonaddr_d;
  logic [2:0]        access_q, access_d;
  logic              autoinc_q, autoinc_d;
  logic              rdondata_q, rdondata_d;
  logic [2:0]        sberror_q, sberror_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_strb_q, req_strb_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy, wr_sbcs, wr_addr, wr_data, rd_data, violation, trigger;
  logic              size_bad, misaligned;
  logic [ADDR_W-1:0] chk_addr, inc;
  logic [31:0]       wr_val, lane_wdata, rd_shift, rd_val;
  logic [3:0]        lane_strb;

  assign busy      = (state_q != S_IDLE);
  assign wr_sbcs   = dmi_wr && (dmi_addr == A_SBCS);
  assign wr_addr   = dmi_wr && (dmi_addr == A_SBADDR);
  assign wr_data   = dmi_wr && (dmi_addr == A_SBDATA);
  assign rd_data   = dmi_rd && (dmi_addr == A_SBDATA);
  assign violation = busy && (wr_addr || wr_data || rd_data);
  assign trigger   = !busy && !busyerr_q && (sberror_q == 3'd0) &&
                     ((wr_addr && rdonaddr_q) || wr_data || (rd_data && rdondata_q));

  // The access uses the value being written this cycle, not the stale register.
  assign chk_addr  = wr_addr ? dmi_wdata[ADDR_W-1:0] : addr_q;
  assign wr_val    = wr_data ? dmi_wdata : data_q;
  assign size_bad  = (access_q > 3'd2) || !MASK4[access_q[1:0]];
  assign inc       = ADDR_W'(1) << req_size_q;
  assign rd_shift  = bus_rsp_rdata >> {req_addr_q[1:0], 3'b000};

  always_comb begin
    case (access_q[1:0])
      2'd0: begin
        lane_strb  = 4'b0001 << chk_addr[1:0];
        lane_wdata = {4{wr_val[7:0]}};
        misaligned = 1'b0;
      end
      2'd1: begin
        lane_strb  = 4'b0011 << chk_addr[1:0];
        lane_wdata = {2{wr_val[15:0]}};
        misaligned = chk_addr[0];
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = wr_val;
        misaligned = |chk_addr[1:0];
      end
    endcase
  end

  always_comb begin
    case (req_size_q)
      2'd0:    rd_val = {24'd0, rd_shift[7:0]};
      2'd1:    rd_val = {16'd0, rd_shift[15:0]};
      default: rd_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busyerr_d   = busyerr_q;
    rdonaddr_d  = rdonaddr_q;
    access_d    = access_q;
    autoinc_d   = autoinc_q;
    rdondata_d  = rdondata_q;
    sberror_d   = sberror_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    req_size_d  = req_size_q;
    cnt_d       = cnt_q;

    if (wr_sbcs) begin
      busyerr_d  = busyerr_q & ~dmi_wdata[22];
      rdonaddr_d = dmi_wdata[20];
      access_d   = dmi_wdata[19:17];
      autoinc_d  = dmi_wdata[16];
      rdondata_d = dmi_wdata[15];
      sberror_d  = sberror_q & ~dmi_wdata[14:12];
    end

    if (violation) begin
      busyerr_d = 1'b1;
    end else begin
      if (wr_addr) addr_d = dmi_wdata[ADDR_W-1:0];
      if (wr_data) data_d = dmi_wdata;
    end

    if (trigger) begin
      if (size_bad) begin
        sberror_d = 3'd4;
      end else if (misaligned) begin
        sberror_d = 3'd3;
      end else begin
        state_d     = S_REQ;
        req_we_d    = wr_data;
        req_addr_d  = chk_addr;
        req_wdata_d = lane_wdata;
        req_strb_d  = lane_strb;
        req_size_d  = access_q[1:0];
      end
    end

    // Completion events below are assigned last so they win over a same-cycle W1C.
    case (state_q)
      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus_rsp_valid) begin
          state_d = S_IDLE;
          if (bus_rsp_err) begin
            sberror_d = 3'd2;
          end else begin
            if (!req_we_q) data_d = rd_val;
            if (autoinc_q) addr_d = addr_q + inc;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = S_IDLE;
          sberror_d = 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busyerr_q   <= 1'b0;
      rdonaddr_q  <= 1'b0;
      access_q    <= 3'd2;
      autoinc_q   <= 1'b0;
      rdondata_q  <= 1'b0;
      sberror_q   <= 3'd0;
      addr_q      <= '0;
      data_q      <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      req_size_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busyerr_q   <= busyerr_d;
      rdonaddr_q  <= rdonaddr_d;
      access_q    <= access_d;
      autoinc_q   <= autoinc_d;
      rdondata_q  <= rdondata_d;
      sberror_q   <= sberror_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;
      req_size_q  <= req_size_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_req_valid = (state_q == S_REQ);
  assign bus_req_we    = req_we_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_wdata = req_wdata_q;
  assign bus_req_strb  = req_strb_q;

  always_comb begin
    dmi_rdata = 32'd0;
    case (dmi_addr)
      A_SBCS:   dmi_rdata = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q,
                             rdondata_q, sberror_q, 7'(ADDR_W), 2'b00, SIZE_MASK};
      A_SBADDR: dmi_rdata = 32'(addr_q);
      A_SBDATA: dmi_rdata = data_q;
      default:  dmi_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dm_sba_engine.sv
// Directed bench for dm_sba_engine: two instances (32-bit full-size, 12-bit word-only),
// selected by 'sel', share one DMI/bus stimulus port; the unselected one sees no strobes.
module tb_dm_sba_engine;

  localparam logic [6:0] SBCS = 7'h38, SBADDR = 7'h39, SBDATA = 7'h3C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [6:0]  dmi_addr = SBCS;
  logic        dmi_wr = 1'b0, dmi_rd = 1'b0;
  logic [31:0] dmi_wdata = '0;
  logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;

  logic [31:0] rdata0, rdata1, wdata0, wdata1;
  logic        valid0, valid1, we0, we1;
  logic [31:0] addr0;
  logic [11:0] addr1;
  logic [3:0]  strb0, strb1;

  logic [31:0] o_rdata, o_wdata, o_addr;
  logic        o_valid, o_we;
  logic [3:0]  o_strb;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dm_sba_engine #(.ADDR_W(32), .SIZE_MASK(3'b111), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dmi_addr(dmi_addr), .dmi_wr(dmi_wr & ~sel), .dmi_rd(dmi_rd & ~sel),
    .dmi_wdata(dmi_wdata), .dmi_rdata(rdata0), .bus_req_valid(valid0), .bus_req_ready(bus_req_ready & ~sel),
    .bus_req_we(we0), .bus_req_addr(addr0), .bus_req_wdata(wdata0), .bus_req_strb(strb0),
    .bus_rsp_valid(bus_rsp_valid & ~sel), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err));

  dm_sba_engine #(.ADDR_W(12), .SIZE_MASK(3'b100), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dmi_addr(dmi_addr), .dmi_wr(dmi_wr & sel), .dmi_rd(dmi_rd & sel),
    .dmi_wdata(dmi_wdata), .dmi_rdata(rdata1), .bus_req_valid(valid1), .bus_req_ready(bus_req_ready & sel),
    .bus_req_we(we1), .bus_req_addr(addr1), .bus_req_wdata(wdata1), .bus_req_strb(strb1),
    .bus_rsp_valid(bus_rsp_valid & sel), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err));

  assign o_rdata = sel ? rdata1 : rdata0;
  assign o_valid = sel ? valid1 : valid0;
  assign o_we    = sel ? we1 : we0;
  assign o_addr  = sel ? {20'd0, addr1} : addr0;
  assign o_wdata = sel ? wdata1 : wdata0;
  assign o_strb  = sel ? strb1 : strb0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    dmi_addr = a; dmi_wdata = d; dmi_wr = 1'b1;
    @(negedge clk);
    dmi_wr = 1'b0;
  endtask

  task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk);
    dmi_addr = a; dmi_rd = 1'b1;
    #1 d = o_rdata;
    @(negedge clk);
    dmi_rd = 1'b0;
  endtask

  task automatic peek(input logic [6:0] a, output logic [31:0] d);
    dmi_addr = a;
    #1 d = o_rdata;
  endtask

  task automatic peek_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] v;
    peek(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic handshake;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
  endtask

  task automatic serve(input string tag, input logic we, input logic [31:0] a, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err, input int stall);
    wait_req(tag);
    repeat (stall) @(negedge clk);
    check_eq({tag, "_we"}, {31'd0, o_we}, {31'd0, we});
    check_eq({tag, "_addr"}, o_addr, a);
    check_eq({tag, "_strb"}, {28'd0, o_strb}, {28'd0, strb});
    if (we) check_eq({tag, "_wdata"}, o_wdata, wd);
    handshake();
    check_eq({tag, "_vdrop"}, {31'd0, o_valid}, 32'd0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = rd; bus_rsp_err = err;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    peek(SBCS, s);
    while (s[21] && n < 30) begin
      @(negedge clk);
      peek(SBCS, s);
      n++;
    end
    check_eq({tag, "_idle"}, {31'd0, s[21]}, 32'd0);
  endtask

  task automatic expect_no_req(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (o_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, "_noreq"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, prev;

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    peek_check("rst_sbcs0", SBCS, 32'h2004_0407);
    peek_check("rst_addr0", SBADDR, 32'h0);
    peek_check("rst_data0", SBDATA, 32'h0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_reqaddr", o_addr, 32'h0);
    sel = 1'b1;
    peek_check("rst_sbcs1", SBCS, 32'h2004_0184);
    sel = 1'b0;

    // 32-bit write, request held over a 2-cycle stall.
    dmi_write(SBCS, 32'h0004_0000);
    dmi_write(SBADDR, 32'h100);
    dmi_write(SBDATA, 32'hDEAD_BEEF);
    check_eq("w32_valid_n1", {31'd0, o_valid}, 32'd1);
    peek_check("w32_busy", SBCS, 32'h2024_0407);
    serve("w32", 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    wait_idle("w32");
    peek_check("w32_sbcs", SBCS, 32'h2004_0407);

    // Byte read via readonaddr + autoincrement.
    dmi_write(SBCS, 32'h0011_0000);
    dmi_write(SBADDR, 32'h203);
    serve("rb", 1'b0, 32'h203, 4'h8, 32'h0, 32'h1122_3344, 1'b0, 0);
    wait_idle("rb");
    peek_check("rb_data", SBDATA, 32'h11);
    peek_check("rb_addr", SBADDR, 32'h204);

    // readondata burst: each sbdata0 read returns the previous word and fetches the next.
    dmi_write(SBCS, 32'h0015_8000);
    dmi_write(SBADDR, 32'h0);
    serve("rod0", 1'b0, 32'h0, 4'hF, 32'h0, 32'hA0A0_A0A0, 1'b0, 0);
    wait_idle("rod0");
    prev = 32'hA0A0_A0A0;
    for (int i = 0; i < 3; i++) begin
      dmi_read(SBDATA, got);
      check_eq($sformatf("rod_rd%0d", i), got, prev);
      serve($sformatf("rod%0d", i + 1), 1'b0, 32'(4 * (i + 1)), 4'hF, 32'h0, 32'hB000_0000 + 32'(i), 1'b0, 0);
      wait_idle($sformatf("rod%0d", i + 1));
      prev = 32'hB000_0000 + 32'(i);
    end
    peek_check("rod_data", SBDATA, 32'hB000_0002);
    peek_check("rod_addr", SBADDR, 32'h10);

    // Response error: sberror=2, data and address untouched.
    dmi_write(SBCS, 32'h0015_0000);
    dmi_write(SBADDR, 32'h40);
    serve("rerr", 1'b0, 32'h40, 4'hF, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
    wait_idle("rerr");
    peek_check("rerr_sbcs", SBCS, 32'h2015_2407);
    peek_check("rerr_data", SBDATA, 32'hB000_0002);
    peek_check("rerr_addr", SBADDR, 32'h40);
    dmi_write(SBCS, 32'h0004_7000);
    peek_check("rerr_clr", SBCS, 32'h2004_0407);

    // Busy violation: second sbdata0 write is dropped and flags sbbusyerror.
    dmi_write(SBDATA, 32'h1234_5678);
    dmi_write(SBDATA, 32'hCAFE_F00D);
    peek_check("bz_sbcs", SBCS, 32'h2064_0407);
    serve("bz", 1'b1, 32'h40, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 0);
    wait_idle("bz");
    peek_check("bz_data", SBDATA, 32'h1234_5678);
    dmi_write(SBDATA, 32'h55);
    expect_no_req("bz_block", 4);
    dmi_write(SBCS, 32'h0044_0000);
    peek_check("bz_clr", SBCS, 32'h2004_0407);

    // Misaligned halfword -> sberror=3, no bus traffic.
    dmi_write(SBCS, 32'h0002_0000);
    dmi_write(SBADDR, 32'h101);
    dmi_write(SBDATA, 32'hABCD);
    peek_check("mis_sbcs", SBCS, 32'h2002_3407);
    expect_no_req("mis", 3);
    dmi_write(SBCS, 32'h0002_7000);
    peek_check("mis_clr", SBCS, 32'h2002_0407);

    // sbaccess=3 -> sberror=4.
    dmi_write(SBCS, 32'h0006_0000);
    dmi_write(SBDATA, 32'h77);
    peek_check("sz3_sbcs", SBCS, 32'h2006_4407);
    expect_no_req("sz3", 3);
    dmi_write(SBCS, 32'h0004_7000);

    // Lane replication for half and byte writes.
    dmi_write(SBCS, 32'h0002_0000);
    dmi_write(SBADDR, 32'h102);
    dmi_write(SBDATA, 32'h0000_BEEF);
    serve("wh", 1'b1, 32'h102, 4'hC, 32'hBEEF_BEEF, 32'h0, 1'b0, 0);
    wait_idle("wh");
    dmi_write(SBCS, 32'h0000_0000);
    dmi_write(SBADDR, 32'h41);
    dmi_write(SBDATA, 32'hA5);
    serve("wb", 1'b1, 32'h41, 4'h2, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    wait_idle("wb");

    // Timeout after 8 cycles in WAIT, trigger blocked until W1C, stray response ignored.
    dmi_write(SBCS, 32'h0004_0000);
    dmi_write(SBADDR, 32'h40);
    dmi_write(SBDATA, 32'h99);
    wait_req("to");
    handshake();
    repeat (7) @(negedge clk);
    peek(SBCS, got);
    check_eq("to_busy7", {31'd0, got[21]}, 32'd1);
    @(negedge clk);
    peek_check("to_sbcs", SBCS, 32'h2004_1407);
    dmi_write(SBDATA, 32'h5);
    expect_no_req("to_block", 3);
    bus_rsp_valid = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    peek_check("to_stray", SBCS, 32'h2004_1407);
    dmi_write(SBCS, 32'h0004_7000);
    peek_check("to_clr", SBCS, 32'h2004_0407);
    dmi_write(SBDATA, 32'h66);
    serve("to_again", 1'b1, 32'h40, 4'hF, 32'h66, 32'h0, 1'b0, 0);
    wait_idle("to_again");

    // Word-only, 12-bit instance: unsupported size and address wrap.
    sel = 1'b1;
    dmi_write(SBCS, 32'h0000_0000);
    dmi_write(SBDATA, 32'h1);
    peek_check("m4_sbcs", SBCS, 32'h2000_4184);
    expect_no_req("m4", 3);
    dmi_write(SBCS, 32'h0005_7000);
    peek_check("m4_clr", SBCS, 32'h2005_0184);
    dmi_write(SBADDR, 32'hFFC);
    dmi_write(SBDATA, 32'h12);
    serve("wrap", 1'b1, 32'hFFC, 4'hF, 32'h12, 32'h0, 1'b0, 0);
    wait_idle("wrap");
    peek_check("wrap_addr", SBADDR, 32'h0);

    // Reset while waiting for a response.
    dmi_write(SBDATA, 32'h34);
    wait_req("rw");
    handshake();
    peek(SBCS, got);
    check_eq("rw_busy", {31'd0, got[21]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rw_valid", {31'd0, o_valid}, 32'd0);
    peek_check("rw_sbcs", SBCS, 32'h2004_0184);
    peek_check("rw_data", SBDATA, 32'h0);
    check_eq("rw_reqaddr", o_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
